// File: rtl/hf_mode_sequencer.sv
// hf_mode_sequencer: HF config register with SPI frame capture and
// glitch-free major-mode sequencing (quiesce -> switch -> settle -> run).
//
// Ports:
//   pck0        sole clock
//   nreset      async active-low reset
//   spck/mosi   SPI clock/data from ARM (async, MSB first)
//   ncs         SPI chip select, active low; rising edge ends a frame
//   conf_word   active configuration, [7:5]=major, [4:0]=minor
//   major_mode  conf_word[7:5], drives mux selects
//   quiesce     high = modes force outputs off
//   mode_ready  high = active mode settled
//   err_count   saturating count of rejected frames
module hf_mode_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int QUIESCE_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 32,
  parameter int CNT_W          = 8
) (
  input  logic             pck0,
  input  logic             nreset,
  input  logic             spck,
  input  logic             mosi,
  input  logic             ncs,
  output logic [7:0]       conf_word,
  output logic [2:0]       major_mode,
  output logic             quiesce,
  output logic             mode_ready,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWITCH,
    SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] Q_LAST =
    CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] spck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   spck_q;
  logic                   ncs_q;
  logic                   spck_s;
  logic                   mosi_s;
  logic                   ncs_s;
  logic                   spck_rise;
  logic                   ncs_rise;
  logic                   ncs_fall;

  logic [15:0]            shift;
  logic [4:0]             bitcnt;
  logic                   frame_ok;
  logic                   frame_bad;
  logic [7:0]             cand;
  logic                   frame_valid;

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic [7:0]             conf_nx;
  logic [7:0]             pend;
  logic [7:0]             pend_nx;

  assign spck_s = spck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  assign spck_rise = spck_s & ~spck_q;
  assign ncs_rise  = ncs_s & ~ncs_q;
  assign ncs_fall  = ~ncs_s & ncs_q;

  assign frame_valid = (bitcnt == 5'd16) &&
                       (shift[15:12] == 4'b0001);

  // ncs idles high so the chain resets to 1 to avoid a false edge
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      spck_sync <= '0;
      mosi_sync <= '0;
      ncs_sync  <= '1;
      spck_q    <= 1'b0;
      ncs_q     <= 1'b1;
    end else begin
      spck_sync <= {spck_sync[SYNC_STAGES-2:0], spck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      spck_q    <= spck_s;
      ncs_q     <= ncs_s;
    end
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      shift     <= '0;
      bitcnt    <= '0;
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;
      cand      <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;
      if (ncs_fall) begin
        bitcnt <= '0;
      end else if (spck_rise && !ncs_s) begin
        shift <= {shift[14:0], mosi_s};
        if (bitcnt != 5'd17) begin
          bitcnt <= bitcnt + 5'd1;
        end
      end
      if (ncs_rise) begin
        frame_ok  <= frame_valid;
        frame_bad <= ~frame_valid;
        cand      <= shift[7:0];
      end
    end
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      err_count <= '0;
    end else if (frame_bad && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      state     <= RUN;
      cnt       <= '0;
      conf_word <= 8'hE0;
      pend      <= 8'hE0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      conf_word <= conf_nx;
      pend      <= pend_nx;
    end
  end

  // Last accepted frame always wins the pending slot
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    conf_nx  = conf_word;
    pend_nx  = frame_ok ? cand : pend;
    unique case (state)
      RUN: begin
        if (frame_ok) begin
          if (cand[7:5] == conf_word[7:5]) begin
            conf_nx[4:0] = cand[4:0];
          end else begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end
        end
      end
      DRAIN: begin
        if (cnt == Q_LAST) begin
          state_nx = SWITCH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      SWITCH: begin
        conf_nx  = pend_nx;
        state_nx = SETTLE;
        cnt_nx   = '0;
      end
      SETTLE: begin
        if (frame_ok && (cand[7:5] != conf_word[7:5])) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else if (cnt == S_LAST) begin
          state_nx     = RUN;
          cnt_nx       = '0;
          conf_nx[4:0] = pend_nx[4:0];
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  assign major_mode = conf_word[7:5];
  assign quiesce    = (state != RUN);
  assign mode_ready = (state == RUN);

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// tb_hf_mode_sequencer: random + directed SPI frames checked
// against a timestamp-based reference model of the mode sequence.
module tb_hf_mode_sequencer;

  localparam int SYNC = 2;
  localparam int QC   = 120;
  localparam int SC   = 150;
  localparam int CW   = 8;
  localparam int H    = 3;
  localparam int LIM  = 4000;
  localparam int EMAX = (1 << CW) - 1;

  logic          pck0   = 1'b0;
  logic          nreset = 1'b0;
  logic          spck   = 1'b0;
  logic          mosi   = 1'b0;
  logic          ncs    = 1'b1;
  logic [7:0]    conf_word;
  logic [2:0]    major_mode;
  logic          quiesce;
  logic          mode_ready;
  logic [CW-1:0] err_count;

  always #5 pck0 = ~pck0;

  hf_mode_sequencer #(
    .SYNC_STAGES(SYNC),
    .QUIESCE_CYCLES(QC),
    .SETTLE_CYCLES(SC),
    .CNT_W(CW)
  ) dut (
    .pck0(pck0),
    .nreset(nreset),
    .spck(spck),
    .mosi(mosi),
    .ncs(ncs),
    .conf_word(conf_word),
    .major_mode(major_mode),
    .quiesce(quiesce),
    .mode_ready(mode_ready),
    .err_count(err_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         land;
    bit         ok;
    logic [7:0] cand;
  } fr_t;

  fr_t        fq[$];
  int         cyc    = 0;
  logic [7:0] m_conf = 8'hE0;
  logic [7:0] m_pend = 8'hE0;
  int         m_err  = 0;
  bit         m_busy = 1'b0;
  int         t_sw   = 0;
  int         t_rdy  = 0;
  bit         chk_en = 1'b0;
  bit         saw010 = 1'b0;

  // Model: a mode change is a pair of deadlines (switch, ready)
  initial forever begin
    @(posedge pck0 or negedge nreset);
    if (!nreset) begin
      m_conf = 8'hE0;
      m_pend = 8'hE0;
      m_err  = 0;
      m_busy = 1'b0;
      fq.delete();
    end else begin
      cyc++;
      while (fq.size() != 0 && fq[0].land <= cyc) begin
        fr_t f;
        f = fq.pop_front();
        if (!f.ok) begin
          if (m_err < EMAX) m_err++;
        end else if (!m_busy) begin
          if (f.cand[7:5] == m_conf[7:5]) begin
            m_conf[4:0] = f.cand[4:0];
          end else begin
            m_busy = 1'b1;
            m_pend = f.cand;
            t_sw   = cyc + QC + 1;
            t_rdy  = t_sw + SC;
          end
        end else begin
          m_pend = f.cand;
          if (cyc > t_sw && f.cand[7:5] != m_conf[7:5]) begin
            t_sw  = cyc + QC + 1;
            t_rdy = t_sw + SC;
          end
        end
      end
      if (m_busy && cyc == t_sw) m_conf = m_pend;
      if (m_busy && cyc == t_rdy) begin
        m_conf = m_pend;
        m_busy = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge pck0);
    if (chk_en) begin
      chk("conf", conf_word, m_conf);
      chk("major", major_mode, m_conf[7:5]);
      chk("quiesce", quiesce, m_busy);
      chk("ready", mode_ready, !m_busy);
      chk("err", err_count, m_err);
      if (major_mode == 3'b010) saw010 = 1'b1;
    end
  end

  // Returns at the negedge on which ncs was raised
  task automatic send_frame(input logic [15:0] d,
                            input int nb);
    fr_t f;
    ncs = 1'b0;
    repeat (4) @(negedge pck0);
    for (int i = 0; i < nb; i++) begin
      mosi = (i < 16) ? d[15-i] : 1'b0;
      repeat (H) @(negedge pck0);
      spck = 1'b1;
      repeat (H) @(negedge pck0);
      spck = 1'b0;
    end
    repeat (H) @(negedge pck0);
    ncs    = 1'b1;
    f.land = cyc + SYNC + 2;
    f.ok   = (nb == 16) && (d[15:12] == 4'h1);
    f.cand = d[7:0];
    fq.push_back(f);
  endtask

  task automatic gap(input int n);
    repeat (SYNC + 3 + n) @(negedge pck0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || fq.size() != 0) && n < LIM) begin
      @(negedge pck0);
      n++;
    end
    chk("idle_wait", int'(n < LIM), 1);
    repeat (2) @(negedge pck0);
  endtask

  initial begin
    int n;
    int m;
    int drops;
    logic [15:0] d;
    int nb;

    repeat (3) @(negedge pck0);
    chk("rst_conf", conf_word, 8'hE0);
    chk("rst_q", quiesce, 0);
    chk("rst_rdy", mode_ready, 1);
    chk("rst_err", err_count, 0);
    nreset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge pck0);

    send_frame(16'h1020, 16);
    n = 0;
    while (!quiesce && n < 50) begin
      @(negedge pck0);
      n++;
    end
    chk("q_lat", n, SYNC + 2);
    m = 0;
    while (major_mode != 3'b001 && m < LIM) begin
      @(negedge pck0);
      m++;
    end
    chk("sw_lat", m, QC + 1);
    n = 0;
    while (!mode_ready && n < LIM) begin
      @(negedge pck0);
      n++;
    end
    chk("rdy_lat", n, SC);
    chk("conf20", conf_word, 8'h20);
    gap(2);

    send_frame(16'h1023, 16);
    n = 0;
    while (conf_word != 8'h23 && n < 50) begin
      @(negedge pck0);
      n++;
    end
    chk("minor_lat", n, SYNC + 2);
    chk("minor_q", quiesce, 0);
    chk("minor_rdy", mode_ready, 1);
    gap(2);

    send_frame(16'h2040, 16);
    gap(0);
    send_frame(16'h1020, 15);
    gap(0);
    wait_idle();
    chk("err2", err_count, 2);
    chk("err_conf", conf_word, 8'h23);

    saw010 = 1'b0;
    send_frame(16'h1040, 16);
    gap(0);
    send_frame(16'h1060, 16);
    wait_idle();
    chk("drain_major", major_mode, 3);
    chk("no_010", saw010, 0);

    send_frame(16'h1040, 16);
    n = 0;
    while (!quiesce && n < 50) begin
      @(negedge pck0);
      n++;
    end
    drops = 0;
    fork
      begin
        int k = 0;
        while (cyc <= t_sw && k < LIM) begin
          @(negedge pck0);
          k++;
        end
        send_frame(16'h1080, 16);
      end
      begin
        int k = 0;
        while (!mode_ready && k < LIM) begin
          if (!quiesce) drops++;
          @(negedge pck0);
          k++;
        end
      end
    join
    wait_idle();
    chk("q_cont", drops, 0);
    chk("settle_major", major_mode, 4);

    send_frame(16'h1020, 16);
    n = 0;
    while (!quiesce && n < 50) begin
      @(negedge pck0);
      n++;
    end
    repeat (10) @(negedge pck0);
    @(posedge pck0);
    #2 nreset = 1'b0;
    #1;
    chk("ar_conf", conf_word, 8'hE0);
    chk("ar_q", quiesce, 0);
    chk("ar_rdy", mode_ready, 1);
    chk("ar_err", err_count, 0);
    @(negedge pck0);
    nreset = 1'b1;
    repeat (3) @(negedge pck0);
    send_frame(16'h1020, 16);
    wait_idle();
    chk("post_rst", conf_word, 8'h20);

    for (int i = 0; i < 60; i++) begin
      d[15:12] = ($urandom_range(0, 4) != 0) ?
                 4'h1 : 4'($urandom);
      d[11:0]  = 12'($urandom);
      case ($urandom_range(0, 9))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      send_frame(d, nb);
      gap($urandom_range(0, 200));
    end
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      send_frame(16'h1000, $urandom_range(0, 3));
      gap(0);
    end
    wait_idle();
    chk("err_sat", err_count, EMAX);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
